// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the RISC-V control path: opcodes, FSM state
// encodings, ALUOp/ALUControl codes and datapath mux selects.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format depends only on the opcode, never on the FSM state.
  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction fields and status in, datapath control out.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic [1:0] ImmSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       AdrSrc;
  logic [2:0] ALUControl;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       IllegalOp;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
           IRWrite, PCWrite, RegWrite, MemWrite, IllegalOp
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
           IRWrite, PCWrite, RegWrite, MemWrite, IllegalOp
  );
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALUOp/funct decode to ALUControl; shared with the
// single-cycle controller.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] ALUControl
);

  // Only R-type (op[5]=1) with funct7b5 selects sub; addi never does.
  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ALUControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I core.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC + 4
// DECODE   | compute branch/jump target, dispatch on opcode
// MEMADR   | effective address for lw/sw
// MEMREAD  | read data memory
// MEMWB    | write loaded data to register file
// MEMWRITE | write data memory
// EXECUTER | R-type ALU operation
// EXECUTEI | I-type ALU operation
// ALUWB    | write ALU result to register file
// BEQ      | compare and conditionally load branch target
// JAL      | load jump target, compute link address
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(S_FETCH),
    DECODE   = STATE_W'(S_DECODE),
    MEMADR   = STATE_W'(S_MEMADR),
    MEMREAD  = STATE_W'(S_MEMREAD),
    MEMWB    = STATE_W'(S_MEMWB),
    MEMWRITE = STATE_W'(S_MEMWRITE),
    EXECUTER = STATE_W'(S_EXECUTER),
    EXECUTEI = STATE_W'(S_EXECUTEI),
    ALUWB    = STATE_W'(S_ALUWB),
    BEQ      = STATE_W'(S_BEQ),
    JAL      = STATE_W'(S_JAL)
  } state_t;

  state_t     state;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;
  logic       ir_write;
  logic       reg_write;
  logic       mem_write;
  logic       illegal;
  logic       op_known;

  assign op_known = (bus.op == OP_LW) || (bus.op == OP_SW) || (bus.op == OP_R) ||
                    (bus.op == OP_I)  || (bus.op == OP_BEQ) || (bus.op == OP_JAL);

  // State register; unused encodings fall back to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:  state <= DECODE;
        DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: state <= MEMADR;
            OP_R:         state <= EXECUTER;
            OP_I:         state <= EXECUTEI;
            OP_JAL:       state <= JAL;
            OP_BEQ:       state <= BEQ;
            default:      state <= FETCH;
          endcase
        end
        MEMADR:   state <= (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
        MEMREAD:  state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: state <= FETCH;
        EXECUTER: state <= ALUWB;
        EXECUTEI: state <= ALUWB;
        ALUWB:    state <= FETCH;
        BEQ:      state <= FETCH;
        JAL:      state <= ALUWB;
        default:  state <= FETCH;
      endcase
    end
  end

  // Moore output decode; anything not set for a state stays 0.
  always_comb begin
    bus.ALUSrcA   = SRCA_PC;
    bus.ALUSrcB   = SRCB_REG;
    bus.ResultSrc = RES_ALUOUT;
    bus.AdrSrc    = 1'b0;
    alu_op        = ALUOP_ADD;
    ir_write      = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    reg_write     = 1'b0;
    mem_write     = 1'b0;
    illegal       = 1'b0;
    case (state)
      FETCH: begin
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        ir_write      = 1'b1;
        pc_update     = 1'b1;
      end
      DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        illegal     = ~op_known;
      end
      MEMADR: begin
        bus.ALUSrcA = SRCA_REG;
        bus.ALUSrcB = SRCB_IMM;
      end
      MEMREAD:  bus.AdrSrc = 1'b1;
      MEMWB: begin
        bus.ResultSrc = RES_DATA;
        reg_write     = 1'b1;
      end
      MEMWRITE: begin
        bus.AdrSrc = 1'b1;
        mem_write  = 1'b1;
      end
      EXECUTER: begin
        bus.ALUSrcA = SRCA_REG;
        alu_op      = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        bus.ALUSrcA = SRCA_REG;
        bus.ALUSrcB = SRCB_IMM;
        alu_op      = ALUOP_FUNCT;
      end
      ALUWB: reg_write = 1'b1;
      BEQ: begin
        bus.ALUSrcA = SRCA_REG;
        alu_op      = ALUOP_SUB;
        branch      = 1'b1;
      end
      JAL: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_FOUR;
        pc_update   = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are held low for the whole reset assertion, including
  // the FETCH state that reset forces.
  assign bus.IRWrite   = ir_write & ~reset;
  assign bus.PCWrite   = (pc_update | (branch & bus.Zero)) & ~reset;
  assign bus.RegWrite  = reg_write & ~reset;
  assign bus.MemWrite  = mem_write & ~reset;
  assign bus.IllegalOp = illegal & ~reset;
  assign bus.ImmSrc    = imm_src(bus.op);

  alu_decoder u_alu_decoder (
    .ALUOp      (alu_op),
    .funct3     (bus.funct3),
    .op5        (bus.op[5]),
    .funct7b5   (bus.funct7b5),
    .ALUControl (bus.ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// through its state sequence and checks the control outputs per cycle.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  multicycle_controller_if bus ();

  multicycle_controller #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {IRWrite, PCWrite, RegWrite, MemWrite, IllegalOp}
  function automatic logic [7:0] we();
    return {3'b000, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.IllegalOp};
  endfunction

  task automatic next();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Starts in a FETCH cycle, ends in the following FETCH cycle.
  task automatic alu_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [2:0] exp_ctl, input string tag);
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7;
    next();  // DECODE
    next();  // EXECUTE
    chk({tag, "_ctl"}, {5'd0, bus.ALUControl}, {5'd0, exp_ctl});
    next();  // ALUWB
    chk({tag, "_wb"}, we(), 8'b0_0100);
    next();  // FETCH
    chk({tag, "_fetch"}, we(), 8'b1_1000);
  endtask

  task automatic beq_instr(input logic zero, input logic [7:0] exp_we, input string tag);
    bus.op = 7'b1100011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.Zero = zero;
    next();  // DECODE
    chk({tag, "_dec_we"}, we(), 8'b0);
    next();  // BEQ
    chk({tag, "_we"}, we(), exp_we);
    chk({tag, "_ctl"}, {5'd0, bus.ALUControl}, 8'b001);
    chk({tag, "_imm"}, {6'd0, bus.ImmSrc}, 8'b10);
    next();  // FETCH
    chk({tag, "_fetch"}, we(), 8'b1_1000);
    bus.Zero = 1'b0;
  endtask

  initial begin
    bus.op = 7'b0000011; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_we", we(), 8'b0);
    chk("rst_srcb", {6'd0, bus.ALUSrcB}, 8'd2);
    chk("rst_adr", {7'd0, bus.AdrSrc}, 8'd0);

    // lw
    reset = 1'b0; #1;
    chk("lw_fetch_we", we(), 8'b1_1000);
    chk("lw_fetch_srcb", {6'd0, bus.ALUSrcB}, 8'd2);
    chk("lw_fetch_ctl", {5'd0, bus.ALUControl}, 8'd0);
    chk("lw_fetch_res", {6'd0, bus.ResultSrc}, 8'd2);
    next();
    chk("lw_dec_src", {4'd0, bus.ALUSrcA, bus.ALUSrcB}, 8'b0101);
    chk("lw_dec_we", we(), 8'b0);
    chk("lw_imm", {6'd0, bus.ImmSrc}, 8'b00);
    next();
    chk("lw_madr_src", {4'd0, bus.ALUSrcA, bus.ALUSrcB}, 8'b1001);
    chk("lw_madr_we", we(), 8'b0);
    next();
    chk("lw_mrd_adr", {7'd0, bus.AdrSrc}, 8'd1);
    chk("lw_mrd_res", {6'd0, bus.ResultSrc}, 8'd0);
    chk("lw_mrd_we", we(), 8'b0);
    next();
    chk("lw_mwb_we", we(), 8'b0_0100);
    chk("lw_mwb_res", {6'd0, bus.ResultSrc}, 8'd1);
    next();
    chk("lw_fetch2_we", we(), 8'b1_1000);

    // R-type and I-type ALU decode
    alu_instr(7'b0110011, 3'b000, 1'b1, 3'b001, "r_sub");
    alu_instr(7'b0110011, 3'b000, 1'b0, 3'b000, "r_add");
    alu_instr(7'b0110011, 3'b010, 1'b0, 3'b101, "r_slt");
    alu_instr(7'b0110011, 3'b110, 1'b0, 3'b011, "r_or");
    alu_instr(7'b0110011, 3'b111, 1'b0, 3'b010, "r_and");
    alu_instr(7'b0110011, 3'b001, 1'b0, 3'b000, "r_other");
    alu_instr(7'b0010011, 3'b000, 1'b1, 3'b000, "i_addi_f7");

    // beq taken and not taken
    beq_instr(1'b1, 8'b0_1000, "beq_t");
    beq_instr(1'b0, 8'b0_0000, "beq_nt");

    // sw
    bus.op = 7'b0100011;
    next();
    next();
    chk("sw_madr_we", we(), 8'b0);
    next();
    chk("sw_mwr_we", we(), 8'b0_0010);
    chk("sw_imm", {6'd0, bus.ImmSrc}, 8'b01);
    chk("sw_adr", {7'd0, bus.AdrSrc}, 8'd1);
    next();
    chk("sw_fetch_we", we(), 8'b1_1000);

    // jal
    bus.op = 7'b1101111;
    next();
    next();
    chk("jal_we", we(), 8'b0_1000);
    chk("jal_src", {4'd0, bus.ALUSrcA, bus.ALUSrcB}, 8'b0110);
    chk("jal_imm", {6'd0, bus.ImmSrc}, 8'b11);
    next();
    chk("jal_wb_we", we(), 8'b0_0100);
    next();
    chk("jal_fetch_we", we(), 8'b1_1000);

    // illegal opcode
    bus.op = 7'b1111111;
    chk("ill_fetch_we", we(), 8'b1_1000);
    next();
    chk("ill_dec_we", we(), 8'b0_0001);
    chk("ill_imm", {6'd0, bus.ImmSrc}, 8'b00);
    next();
    chk("ill_fetch2_we", we(), 8'b1_1000);

    // reset asserted mid-lw in MEMREAD
    bus.op = 7'b0000011;
    next();
    next();
    next();
    chk("mr_memread_adr", {7'd0, bus.AdrSrc}, 8'd1);
    #1 reset = 1'b1;
    #1;
    chk("mr_async_we", we(), 8'b0);
    chk("mr_async_adr", {7'd0, bus.AdrSrc}, 8'd0);
    next();
    chk("mr_hold_we", we(), 8'b0);
    reset = 1'b0; #1;
    chk("mr_fetch_we", we(), 8'b1_1000);
    chk("mr_fetch_srca", {6'd0, bus.ALUSrcA}, 8'd0);
    next();
    chk("mr_dec_srca", {6'd0, bus.ALUSrcA}, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control FSM that sequences the shared 32-bit alu, memory and register file of the multicycle RISC-V core (RV32I subset: lw, sw, R-type, I-type ALU, beq, jal).
- Decodes the latched instruction fields.
- Steps a Moore FSM through fetch/decode/execute/writeback.
- Drives the alu's ALUControl and the datapath mux selects and write enables each cycle.
- Sits between the instruction register and the multicycle datapath.

Parameters:
STATE_W, 4, width of the state register (11 states are used; the value must be at least 4).

Ports:
clk  in  1  single system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
op  in  7  instruction[6:0] from the instruction register.
funct3  in  3  instruction[14:12].
funct7b5  in  1  instruction[30].
Zero  in  1  alu zero flag, sampled in the BEQ state.
ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = register A.
ALUSrcB  out  2  00 = register B, 01 = ImmExt, 10 = constant 4.
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
IRWrite  out  1  instruction register load enable.
PCWrite  out  1  PC load enable.
RegWrite  out  1  register file write enable.
MemWrite  out  1  data memory write enable.
IllegalOp  out  1  one-cycle pulse when an unsupported opcode is decoded.

Behaviour:
- Reset:
  - Clock and reset are as stated: one clock, clk; reset is asynchronous and active-high.
  - reset asserted forces state to FETCH immediately.
  - While reset is high, IRWrite, PCWrite, RegWrite, MemWrite and IllegalOp are forced to 0.
  - Other outputs take their FETCH values.
  - If reset asserts mid-instruction, that instruction is abandoned and no write occurs.
- Output and state-update rules:
  - Moore outputs decode combinationally from state; signals not listed for a state are 0.
  - The state register updates on the rising clk edge only.
- ImmSrc is decoded from op alone, independent of state:
  - 0000011 and 0010011 → 00
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - other opcodes → 00
- Per-state outputs and transitions:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. → DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target). Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1101111 → JAL
    - 1100011 → BEQ
    - otherwise → FETCH with IllegalOp=1 for this cycle
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. → MEMREAD if op=0000011, else → MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. → MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. → FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. → FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. → ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. → ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. → FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. → FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. → ALUWB.
- PCWrite = PCUpdate | (Branch & Zero).
- ALU decode:
  - ALUOp 00 → 000 (add); ALUOp 01 → 001 (sub).
  - ALUOp 10, by funct3:
    - 000: 001 (sub) if op[5] & funct7b5, else 000 (add)
    - 010 → 101
    - 110 → 011
    - 111 → 010
    - any other funct3 → 000
  - ALUOp 11 → 000.
- Latency in cycles, FETCH through the last state inclusive: lw 5; sw 4; R-type 4; I-type 4; beq 3; jal 4; illegal 2.
- The state register must never sit in an unused encoding; any unused encoding → FETCH on the next edge.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - state encodings (11 states)
  - ALUOp codes
  - ALUControl codes (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT), shared with alu
  - mux-select constants
- One sub-module, alu_decoder: inputs ALUOp, funct3, op[5], funct7b5; output ALUControl. It is purely combinational and reusable by the single-cycle controller.
- The FSM and ImmSrc decode stay in multicycle_controller.

Test Plan:
- Reset and fetch: reset=1 for 3 cycles with op=0000011 → all write enables 0 during reset. First cycle after release: IRWrite=1, PCWrite=1, ALUSrcB=10, ALUControl=000.
- lw: op=0000011 → IRWrite=1, then MEMADR (ALUSrcA=10, ALUSrcB=01), then AdrSrc=1, then RegWrite=1 with ResultSrc=01. Back in FETCH on cycle 6; MemWrite stays 0 throughout.
- R-type sub: op=0110011, funct3=000, funct7b5=1 → cycle 3 ALUControl=001, cycle 4 RegWrite=1. With funct7b5=0 → 000. funct3=010 → 101, 110 → 011, 111 → 010.
- beq: op=1100011, Zero=1 in cycle 3 → PCWrite=1, ALUControl=001, ImmSrc=10. Repeat with Zero=0 → PCWrite=0; both return to FETCH on cycle 4.
- sw and jal:
  - sw (op=0100011) → MemWrite=1 only in cycle 4, ImmSrc=01, RegWrite never set.
  - jal (op=1101111) → cycle 3 PCWrite=1 with ALUSrcA=01 and ALUSrcB=10, cycle 4 RegWrite=1, ImmSrc=11.
- Illegal opcode and mid-op reset:
  - op=1111111 → IllegalOp=1 for exactly the DECODE cycle, FETCH next, no write enables.
  - Assert reset asynchronously during MEMREAD of a lw → RegWrite stays 0 and the FSM restarts in FETCH after release.
